fifo_reader: RTL and testbench

Read-side consumer for the team's synchronous FIFO (WIDTH/DEPTH-parameterised, registered `data_out`). It issues `rd_en` only when data and downstream space exist, absorbs the FIFO's one-cycle read latency in a 2-entry skid buffer, and presents the words on a valid/ready stream at up to one word per cycle. It sits between the FIFO's read port and any consumer, and it counts accepted words and flags underflows.

---
 rtl/fifo_reader_if.sv | 36 +++
 rtl/fifo_reader.sv | 115 +++++++++++
 tb/tb_fifo_reader.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_reader_if.sv
// Read-port and stream bundle for fifo_reader.
// FIFO read side plus the valid/ready output stream.
interface fifo_reader_if #(
    parameter int WIDTH = 16
);
    logic             empty;
    logic             almostempty;
    logic             underflow;
    logic [WIDTH-1:0] data_out;
    logic             rd_en;
    logic [WIDTH-1:0] m_data;
    logic             m_valid;
    logic             m_ready;

    modport master (
        input  empty,
        input  almostempty,
        input  underflow,
        input  data_out,
        input  m_ready,
        output rd_en,
        output m_data,
        output m_valid
    );

    modport slave (
        output empty,
        output almostempty,
        output underflow,
        output data_out,
        output m_ready,
        input  rd_en,
        input  m_data,
        input  m_valid
    );
endinterface

// File: rtl/fifo_reader.sv
// FIFO read-side consumer: credit-gated rd_en,
// 2-entry skid buffer, pop counter, sticky underflow.
module fifo_reader #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    fifo_reader_if.master    bus,
    output logic             busy,
    output logic [CNT_W-1:0] pop_count,
    output logic             uflow_err
);
    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        FLUSH
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       occ_q, occ_d;
    logic             infl_q;
    logic [WIDTH-1:0] head_q, head_d;
    logic [WIDTH-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    logic       pop;
    logic       push;
    logic       rd;
    logic [2:0] credit;

    // Read strobe: issued only when a slot is guaranteed.
    always_comb begin
        pop    = (occ_q != 2'd0) && bus.m_ready;
        push   = infl_q && !bus.underflow;
        credit = 3'd2 - {1'b0, occ_q}
               - {2'b0, infl_q} + {2'b0, pop};
        rd     = (state_q == ACTIVE)
              && !bus.empty
              && (credit != 3'd0)
              && !(bus.almostempty && infl_q);
    end

    // Next state of FSM, skid buffer, counter and error.
    always_comb begin
        state_d = state_q;
        occ_d   = occ_q;
        head_d  = head_q;
        tail_d  = tail_q;
        cnt_d   = cnt_q;
        err_d   = err_q;

        unique case (state_q)
            IDLE:    if (en) state_d = ACTIVE;
            ACTIVE:  if (!en) state_d = FLUSH;
            FLUSH:   if (!infl_q && occ_q == 2'd0)
                         state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (infl_q && bus.underflow) err_d = 1'b1;
        if (push) cnt_d = cnt_q + 1'b1;

        unique case (1'b1)
            push && pop: begin
                if (occ_q == 2'd1) begin
                    head_d = bus.data_out;
                end else begin
                    head_d = tail_q;
                    tail_d = bus.data_out;
                end
            end
            push && !pop: begin
                if (occ_q == 2'd0) head_d = bus.data_out;
                else               tail_d = bus.data_out;
                occ_d = occ_q + 2'd1;
            end
            !push && pop: begin
                head_d = tail_q;
                occ_d  = occ_q - 2'd1;
            end
            default: ;
        endcase
    end

    // State registers; reset discards buffered and in-flight words.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            occ_q   <= 2'd0;
            infl_q  <= 1'b0;
            head_q  <= '0;
            tail_q  <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            occ_q   <= occ_d;
            infl_q  <= rd;
            head_q  <= head_d;
            tail_q  <= tail_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign bus.rd_en   = rd;
    assign bus.m_valid = (occ_q != 2'd0);
    assign bus.m_data  = head_q;
    assign busy        = (state_q != IDLE);
    assign pop_count   = cnt_q;
    assign uflow_err   = err_q;
endmodule

// File: tb/tb_fifo_reader.sv
// Bench for fifo_reader: FIFO emulation with one-cycle
// stale flags, queue-based reference model, directed tests.
module tb_fifo_reader;
    localparam int W = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en;
    logic          busy;
    logic          uflow_err;
    logic [15:0]   pop_count;

    fifo_reader_if #(.WIDTH(W)) bus ();

    fifo_reader #(.WIDTH(W), .CNT_W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .bus       (bus),
        .busy      (busy),
        .pop_count (pop_count),
        .uflow_err (uflow_err)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(string name, logic [31:0] act,
                       logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h",
                     name, act, exp);
        end
    endtask

    // FIFO emulation
    logic [15:0] stage[$];
    logic [15:0] fq[$];
    logic        rd_s    = 1'b0;
    bit          force_uf = 1'b0;
    bit          ufn;
    int          nat_uf  = 0;
    int          sz;
    int          cyc     = 0;

    always @(posedge clk) begin
        cyc++;
        sz = fq.size();
        bus.empty       <= (sz == 0);
        bus.almostempty <= (sz == 1);
        ufn = 1'b0;
        if (rd_s) begin
            if (sz > 0) begin
                bus.data_out <= fq.pop_front();
            end else begin
                ufn = 1'b1;
                nat_uf++;
            end
        end
        bus.underflow <= ufn | force_uf;
        while (stage.size() > 0)
            fq.push_back(stage.pop_front());
    end

    // Reference model and per-cycle compare
    int          mstate = 0;
    logic [15:0] mq[$];
    bit          minf   = 1'b0;
    logic [15:0] mcnt   = '0;
    bit          merr   = 1'b0;
    bit          armed  = 1'b0;

    logic [15:0] got[$];
    int          gotcyc[$];
    int          rd_pulses = 0;
    int          first_rd  = -1;

    always @(negedge clk) begin : model
        bit ev;
        bit erd;
        bit pop;
        int cr;
        int nst;
        rd_s = bus.rd_en;
        ev   = (mq.size() != 0);
        pop  = ev && (bus.m_ready === 1'b1);
        cr   = 2 - mq.size() - int'(minf) + int'(pop);
        erd  = (mstate == 1) && !bus.empty && cr >= 1
            && !(bus.almostempty && minf);
        if (armed) begin
            chk("rd_en", 32'(bus.rd_en), 32'(erd));
            chk("m_valid", 32'(bus.m_valid), 32'(ev));
            if (ev) chk("m_data", 32'(bus.m_data), 32'(mq[0]));
            chk("busy", 32'(busy), 32'(mstate != 0));
            chk("pop_count", 32'(pop_count), 32'(mcnt));
            chk("uflow_err", 32'(uflow_err), 32'(merr));
        end
        if (bus.rd_en === 1'b1) begin
            rd_pulses++;
            if (first_rd < 0) first_rd = cyc;
        end
        if (bus.m_valid === 1'b1 && bus.m_ready === 1'b1) begin
            got.push_back(bus.m_data);
            gotcyc.push_back(cyc);
        end
        nst = mstate;
        if (mstate == 0 && en) nst = 1;
        if (mstate == 1 && !en) nst = 2;
        if (mstate == 2 && !minf && mq.size() == 0) nst = 0;
        if (pop) void'(mq.pop_front());
        if (minf) begin
            if (bus.underflow) merr = 1'b1;
            else begin
                mq.push_back(bus.data_out);
                mcnt = mcnt + 16'd1;
            end
        end
        if (mq.size() > 2) begin
            checks++;
            failures++;
            $display("FAIL skid_overflow actual=%0d required<=2",
                     mq.size());
        end
        minf   = erd;
        mstate = nst;
        if (!rst_n) begin
            mstate = 0;
            mq.delete();
            minf  = 1'b0;
            mcnt  = '0;
            merr  = 1'b0;
            armed = 1'b1;
        end
    end

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n       = 1'b0;
        en          = 1'b0;
        bus.m_ready = 1'b1;
        tick(3);
        chk("rst_m_valid", 32'(bus.m_valid), 0);
        chk("rst_m_data", 32'(bus.m_data), 0);
        chk("rst_rd_en", 32'(bus.rd_en), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_pop_count", 32'(pop_count), 0);
        chk("rst_uflow_err", 32'(uflow_err), 0);
        rst_n = 1'b1;
        tick(1);

        // Streaming 8 words at full rate
        got.delete();
        gotcyc.delete();
        rd_pulses = 0;
        for (int i = 1; i <= 8; i++) stage.push_back(16'(i));
        tick(3);
        en = 1'b1;
        tick(16);
        chk("t1_count", got.size(), 8);
        for (int i = 0; i < 8 && i < got.size(); i++) begin
            chk("t1_word", 32'(got[i]), 32'(i + 1));
            chk("t1_cycle", gotcyc[i], first_rd + 2 + i);
        end
        chk("t1_pop_count", 32'(pop_count), 8);
        chk("t1_uflow_err", 32'(uflow_err), 0);
        chk("t1_rd_pulses", rd_pulses, 8);

        // Backpressure with a full FIFO
        bus.m_ready = 1'b0;
        got.delete();
        rd_pulses = 0;
        for (int i = 1; i <= 8; i++) stage.push_back(16'(i));
        tick(12);
        chk("t2_rd_pulses_held", rd_pulses, 2);
        chk("t2_m_valid", 32'(bus.m_valid), 1);
        chk("t2_m_data", 32'(bus.m_data), 1);
        chk("t2_pop_count_held", 32'(pop_count), 10);
        bus.m_ready = 1'b1;
        tick(16);
        chk("t2_count", got.size(), 8);
        for (int i = 0; i < 8 && i < got.size(); i++)
            chk("t2_word", 32'(got[i]), 32'(i + 1));
        chk("t2_pop_count", 32'(pop_count), 16);
        chk("t2_rd_pulses", rd_pulses, 8);

        // Single word with almostempty
        got.delete();
        rd_pulses = 0;
        stage.push_back(16'h00AA);
        tick(10);
        chk("t3_rd_pulses", rd_pulses, 1);
        chk("t3_count", got.size(), 1);
        if (got.size() > 0) chk("t3_word", 32'(got[0]), 32'h00AA);
        chk("t3_no_underflow", nat_uf, 0);
        chk("t3_pop_count", 32'(pop_count), 17);

        // Forced underflow drops the word
        force_uf = 1'b1;
        got.delete();
        rd_pulses = 0;
        stage.push_back(16'h00BB);
        tick(10);
        chk("t4_rd_pulses", rd_pulses, 1);
        chk("t4_count", got.size(), 0);
        chk("t4_pop_count", 32'(pop_count), 17);
        chk("t4_uflow_err", 32'(uflow_err), 1);
        force_uf = 1'b0;
        tick(3);
        chk("t4_uflow_sticky", 32'(uflow_err), 1);

        // Flush with a full skid buffer
        bus.m_ready = 1'b0;
        for (int i = 0; i < 4; i++)
            stage.push_back(16'h0041 + 16'(i));
        tick(8);
        chk("t5_m_valid", 32'(bus.m_valid), 1);
        chk("t5_m_data", 32'(bus.m_data), 32'h0041);
        got.delete();
        en          = 1'b0;
        bus.m_ready = 1'b1;
        tick(1);
        rd_pulses = 0;
        tick(10);
        chk("t5_rd_after_flush", rd_pulses, 0);
        chk("t5_count", got.size(), 3);
        for (int i = 0; i < 3 && i < got.size(); i++)
            chk("t5_word", 32'(got[i]), 32'h0041 + i);
        chk("t5_busy", 32'(busy), 0);
        chk("t5_pop_count", 32'(pop_count), 20);

        // Reset mid-stream with two words buffered
        bus.m_ready = 1'b0;
        en          = 1'b1;
        stage.push_back(16'h0051);
        stage.push_back(16'h0052);
        tick(8);
        chk("t6_m_valid_pre", 32'(bus.m_valid), 1);
        chk("t6_pop_count_pre", 32'(pop_count), 22);
        rst_n = 1'b0;
        tick(1);
        chk("t6_m_valid", 32'(bus.m_valid), 0);
        chk("t6_rd_en", 32'(bus.rd_en), 0);
        chk("t6_pop_count", 32'(pop_count), 0);
        chk("t6_busy", 32'(busy), 0);
        chk("t6_uflow_err", 32'(uflow_err), 0);
        rst_n = 1'b1;
        en    = 1'b0;
        tick(3);

        $display("TB_RESULT checks=%0d failures=%0d",
                 checks, failures);
        $finish;
    end
endmodule
